// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle controller
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_R      = 3'd1,
        CL_I      = 3'd2,
        CL_LUI    = 3'd3,
        CL_LOAD   = 3'd4,
        CL_STORE  = 3'd5,
        CL_BRANCH = 3'd6
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam logic [1:0] SRC_B_RS2 = 2'b00;
    localparam logic [1:0] SRC_B_IMM = 2'b01;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASS  = 2'b11;

endpackage

// File: rtl/mc_opcode_decoder.sv
// rtl/mc_opcode_decoder.sv - opcode to instruction class and legal flag (branch legality via MC_BRANCH_SUPPORT_EN)
module mc_opcode_decoder
    import mc_pkg::*;
(
    input  logic [6:0] op,
    output iclass_t    iclass,
    output logic       legal
);

    // Classify the opcode; branches are only legal when branch support is built in
    always_comb begin
        iclass = CL_NONE;
        legal  = 1'b0;
        case (op)
            OP_R:      begin iclass = CL_R;     legal = 1'b1; end
            OP_I:      begin iclass = CL_I;     legal = 1'b1; end
            OP_LUI:    begin iclass = CL_LUI;   legal = 1'b1; end
            OP_LOAD:   begin iclass = CL_LOAD;  legal = 1'b1; end
            OP_STORE:  begin iclass = CL_STORE; legal = 1'b1; end
            OP_BRANCH: begin
                iclass = CL_BRANCH;
`ifdef MC_BRANCH_SUPPORT_EN
                legal  = 1'b1;
`else
                legal  = 1'b0;
`endif
            end
            default:   begin iclass = CL_NONE;  legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM (branch support via MC_BRANCH_SUPPORT_EN)
module multicycle_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op_i,
    input  logic        mem_ready_i,
    input  logic        zero_i,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        ir_write_o,
    output logic        imm_latch_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        reg_write_o,
    output logic        illegal_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [2:0]  state_o,
    output logic [31:0] instr_count_o
);

    state_t      state_q;
    logic [6:0]  op_q;
    logic [31:0] count_q;
    logic [6:0]  dec_op;
    iclass_t     iclass;
    logic        legal;

    // DECODE judges the live opcode; every later state works from the latched copy
    assign dec_op = (state_q == ST_DECODE) ? op_i : op_q;

    mc_opcode_decoder u_dec (
        .op     (dec_op),
        .iclass (iclass),
        .legal  (legal)
    );

    assign state_o       = state_q;
    assign instr_count_o = count_q;

    // State sequencing, opcode latch and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= 7'd0;
            count_q <= 32'd0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready_i) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    op_q    <= op_i;
                    state_q <= legal ? ST_EXEC : ST_TRAP;
                end
                ST_EXEC: begin
                    case (iclass)
                        CL_R, CL_I, CL_LUI: state_q <= ST_WB;
                        CL_LOAD, CL_STORE:  state_q <= ST_MEM;
                        CL_BRANCH: begin
                            state_q <= ST_FETCH;
                            count_q <= count_q + 32'd1;
                        end
                        default:            state_q <= ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        if (iclass == CL_LOAD) begin
                            state_q <= ST_WB;
                        end else begin
                            state_q <= ST_FETCH;
                            count_q <= count_q + 32'd1;
                        end
                    end
                end
                ST_WB: begin
                    state_q <= ST_FETCH;
                    count_q <= count_q + 32'd1;
                end
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Control strobes from the current state; memory handshake and branch are Mealy, all silenced in reset
    always_comb begin
        pc_write_o  = 1'b0;
        pc_src_o    = 1'b0;
        ir_write_o  = 1'b0;
        imm_latch_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        reg_write_o = 1'b0;
        illegal_o   = 1'b0;
        alu_src_b_o = SRC_B_RS2;
        alu_op_o    = ALU_ADD;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                    end
                end
                ST_DECODE: imm_latch_o = 1'b1;
                ST_EXEC: begin
                    case (iclass)
                        CL_R:     begin alu_src_b_o = SRC_B_RS2; alu_op_o = ALU_FUNCT; end
                        CL_I:     begin alu_src_b_o = SRC_B_IMM; alu_op_o = ALU_FUNCT; end
                        CL_LUI:   begin alu_src_b_o = SRC_B_IMM; alu_op_o = ALU_PASS;  end
                        CL_LOAD,
                        CL_STORE: begin alu_src_b_o = SRC_B_IMM; alu_op_o = ALU_ADD;   end
                        CL_BRANCH: begin
                            alu_src_b_o = SRC_B_RS2;
                            alu_op_o    = ALU_SUB;
                            pc_write_o  = zero_i;
`ifdef MC_BRANCH_SUPPORT_EN
                            pc_src_o    = zero_i;
`endif
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (iclass == CL_LOAD)       mem_read_o  = 1'b1;
                    else if (iclass == CL_STORE) mem_write_o = 1'b1;
                end
                ST_WB:   reg_write_o = 1'b1;
                ST_TRAP: illegal_o   = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
